// File: rtl/occ_pkg.sv
// Shared constants and request-source encoding for the occupancy arbiter.
// Sources are numbered in round-robin order: lane 0 enter/exit, then lane 1.
package occ_pkg;
   localparam int CAPACITY_DEFAULT = 15;
   localparam int COUNT_W          = 4;

   typedef enum logic [1:0] {
      SRC_E0 = 2'd0,
      SRC_X0 = 2'd1,
      SRC_E1 = 2'd2,
      SRC_X1 = 2'd3
   } src_e;

   // Next source in round-robin order, wrapping X1 back to E0.
   function automatic src_e src_after(input src_e s);
      return src_e'(s + 2'd1);
   endfunction
endpackage

// File: rtl/occupancy_arbiter_if.sv
// Request/status bundle between the lane sensors and the occupancy arbiter.
// The sensor side uses the master modport and the arbiter uses the slave modport.
interface occupancy_arbiter_if;
   import occ_pkg::*;

   logic [1:0]         enter_req;
   logic [1:0]         exit_req;
   logic               inc;
   logic               dec;
   logic [COUNT_W-1:0] count;
   logic               full;
   logic               empty;
   logic [1:0]         deny;
   logic               err;

   modport master (
      output enter_req, exit_req,
      input  inc, dec, count, full, empty, deny, err
   );

   modport slave (
      input  enter_req, exit_req,
      output inc, dec, count, full, empty, deny, err
   );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: one-hot grant, search starts at the pointer,
// and the pointer advances past the grantee only when something is granted.
module rr_arbiter4
   import occ_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] request,
   output logic [3:0] grant
);
   src_e       ptr_reg;
   src_e       grantee;
   logic       found;
   logic [1:0] idx;

   always_comb begin
      grant   = '0;
      grantee = ptr_reg;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_reg + 2'(i);
         if (!found && request[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grantee    = src_e'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg <= SRC_E0;
      end else if (found) begin
         ptr_reg <= src_after(grantee);
      end
   end
endmodule

// File: rtl/occupancy_arbiter.sv
// Merges two lanes of enter/exit pulses into a single occupancy count,
// serialising them one grant per cycle and flagging overruns and underflows.
module occupancy_arbiter
   import occ_pkg::*;
#(
   parameter int CAPACITY = CAPACITY_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   occupancy_arbiter_if.slave bus
);
   localparam logic [COUNT_W-1:0] CAP = COUNT_W'(CAPACITY);

   logic [3:0]         req_vec;
   logic [3:0]         grant;
   logic [3:0]         overrun;
   logic [3:0]         pending_reg, pending_next;
   logic [COUNT_W-1:0] count_reg, count_next;
   logic               inc_reg, inc_next;
   logic               dec_reg, dec_next;
   logic [1:0]         deny_reg, deny_next;
   logic               err_reg, err_next;
   logic               full_reg, empty_reg;
   logic               enter_grant, exit_grant;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign req_vec[2*gi]   = bus.enter_req[gi];
         assign req_vec[2*gi+1] = bus.exit_req[gi];
      end
   endgenerate

   rr_arbiter4 u_rr (
      .clk     (clk),
      .reset   (reset),
      .request (pending_reg),
      .grant   (grant)
   );

   assign enter_grant = grant[SRC_E0] | grant[SRC_E1];
   assign exit_grant  = grant[SRC_X0] | grant[SRC_X1];
   // A new pulse on a source that is still waiting is lost in the merge.
   assign overrun     = req_vec & pending_reg & ~grant;

   always_comb begin
      pending_next = (pending_reg & ~grant) | req_vec;
      count_next   = count_reg;
      inc_next     = 1'b0;
      dec_next     = 1'b0;
      deny_next    = '0;
      err_next     = err_reg | (|overrun);
      if (enter_grant) begin
         if (count_reg < CAP) begin
            count_next = count_reg + COUNT_W'(1);
            inc_next   = 1'b1;
         end else begin
            deny_next = {grant[SRC_E1], grant[SRC_E0]};
         end
      end else if (exit_grant) begin
         if (count_reg != '0) begin
            count_next = count_reg - COUNT_W'(1);
            dec_next   = 1'b1;
         end else begin
            err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg <= '0;
         count_reg   <= '0;
         inc_reg     <= 1'b0;
         dec_reg     <= 1'b0;
         deny_reg    <= '0;
         err_reg     <= 1'b0;
         full_reg    <= 1'b0;
         empty_reg   <= 1'b1;
      end else begin
         pending_reg <= pending_next;
         count_reg   <= count_next;
         inc_reg     <= inc_next;
         dec_reg     <= dec_next;
         deny_reg    <= deny_next;
         err_reg     <= err_next;
         full_reg    <= (count_next == CAP);
         empty_reg   <= (count_next == '0);
      end
   end

   assign bus.inc   = inc_reg;
   assign bus.dec   = dec_reg;
   assign bus.count = count_reg;
   assign bus.full  = full_reg;
   assign bus.empty = empty_reg;
   assign bus.deny  = deny_reg;
   assign bus.err   = err_reg;
endmodule

// File: doc/occupancy_arbiter.md
OCCUPANCY_ARBITER -- requirements
Module: occupancy_arbiter

Interface
REQ-001 SHALL have parameter CAPACITY, default 15, meaning the maximum occupancy accepted (1..15).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port enter_req, input, 2, one-cycle enter pulse per lane (bit0 = lane 0, bit1 = lane 1) from the lane sensor FSMs.
REQ-005 SHALL have port exit_req, input, 2, one-cycle exit pulse per lane.
REQ-006 SHALL have port inc, output, 1, one-cycle pulse when occupancy is incremented.
REQ-007 SHALL have port dec, output, 1, one-cycle pulse when occupancy is decremented.
REQ-008 SHALL have port count, output, 4, current occupancy.
REQ-009 SHALL have port full, output, 1, high when count == CAPACITY.
REQ-010 SHALL have port empty, output, 1, high when count == 0.
REQ-011 SHALL have port deny, output, 2, one-cycle per-lane pulse for an enter refused at capacity.
REQ-012 SHALL have port err, output, 1, sticky flag for request overrun or exit underflow.

Function
REQ-013 SHALL hold four pending bits: sources E0, X0, E1, X1 (round-robin order); a request pulse sets its bit at the next edge.
REQ-014 SHALL grant at most one pending source per cycle, chosen round-robin starting at the pointer; after a grant the pointer moves to grantee+1 mod 4; with no grant the pointer holds.
REQ-015 Granted enter with count < CAPACITY: SHALL pulse inc and increment count on the same edge, so both are visible in the same cycle.
REQ-016 Granted enter with count == CAPACITY: SHALL pulse deny for that lane and leave count, inc and dec unchanged.
REQ-017 Granted exit with count > 0: SHALL pulse dec and decrement count on the same edge.
REQ-018 Granted exit with count == 0: SHALL set err, issue no dec, and leave count at 0 (no wrap).
REQ-019 Every grant SHALL clear the granted pending bit.
REQ-020 Latency: a request seen at edge N with no competing pending sources SHALL produce inc/dec/deny in the cycle after edge N+1.
REQ-021 inc and dec SHALL never be high in the same cycle; all outputs SHALL be registered.
REQ-022 A request arriving while its pending bit is already set and not being granted that cycle SHALL set err; the request is absorbed and counted once.
REQ-023 A request arriving in the cycle its pending bit is granted SHALL re-set the bit, with no err.
REQ-024 Simultaneous requests from all four sources SHALL be served in four consecutive cycles, in pointer order.
REQ-025 full and empty SHALL be derived from the registered count and update in the same cycle as count.

Reset
REQ-026 While reset is high: count = 0, empty = 1, full = 0, inc = dec = 0, deny = 0, err = 0, pending = 0, pointer = E0.
REQ-027 Reset asserted mid-operation SHALL discard all pending requests immediately, without waiting for a clock edge.
REQ-028 The first grant after reset deasserts SHALL be evaluated from pointer E0.

Structure
REQ-029 Package occ_pkg SHALL hold CAPACITY_DEFAULT, the 2-bit source encoding (E0, X0, E1, X1) and COUNT_W = 4.
REQ-030 The arbiter SHALL be a sub-module rr_arbiter4: 4-bit request in, one-hot grant out, internal pointer.
REQ-031 Pending bits, the occupancy counter and the err flag SHALL reside in occupancy_arbiter.

Verification
REQ-032 Reset, then enter_req = 01 for one cycle -> inc pulse two edges later, count = 1, empty = 0.
REQ-033 count = 3, enter_req = 11 and exit_req = 11 in the same cycle -> inc, dec, inc, dec over 4 cycles (E0, X0, E1, X1), final count = 3, err = 0.
REQ-034 CAPACITY = 2, three enters on lane 1 spaced 3 cycles apart -> inc, inc, then deny = 10; count = 2, full = 1.
REQ-035 count = 0, exit_req = 01 -> no dec, err = 1, count stays 0.
REQ-036 enter_req[0] pulsed twice before the first is granted (lane 1 hogging) -> err = 1, exactly one inc for lane 0.
REQ-037 Reset asserted between edges while 3 requests are pending -> count = 0 and pending cleared immediately; after release, no inc or dec is issued.
